// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant.
// Define RR_ARB_TIMEOUT_EN to enable forced release after MAX_HOLD cycles.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic       gnt_vld,
   output logic       tmo
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [2:0] widx;
   logic [2:0] pick;
   logic       hit;

   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_chk
      $error("rr_arbiter8: MAX_HOLD out of range");
   end

   // Lowest offset from ptr wins, so scan downward and let the last hit stick.
   always_comb begin
      pick = ptr;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr + 3'(k)]) pick = ptr + 3'(k);
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] hold;

   assign hit = (hold == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
      end else if (state == IDLE) begin
         hold <= '0;
      end else if (!hit) begin
         hold <= hold + 8'd1;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         tmo     <= 1'b0;
         ptr     <= '0;
         widx    <= '0;
      end else begin
         tmo <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  gnt     <= 8'b1 << pick;
                  gnt_vld <= 1'b1;
                  widx    <= pick;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (!req[widx] || hit) begin
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  ptr     <= widx + 3'd1;
                  tmo     <= req[widx] & hit;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of rr_arbiter8
// against a cycle-level reference model.
module tb_rr_arbiter8;

   localparam int MH = 4;
`ifdef RR_ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic       gnt_vld;
   logic       tmo;

   int n_chk = 0;
   int n_err = 0;

   // reference model: who holds the grant, for how long, and who is next
   bit m_busy;
   int m_win;
   int m_ptr;
   int m_held;
   bit m_tmo;

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .gnt(gnt),
      .gnt_vld(gnt_vld),
      .tmo(tmo)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_gnt();
      return m_busy ? 8'(1 << m_win) : 8'h00;
   endfunction

   task automatic m_reset();
      m_busy = 0;
      m_win  = 0;
      m_ptr  = 0;
      m_held = 0;
      m_tmo  = 0;
   endtask

   task automatic m_edge(input logic [7:0] r);
      m_tmo = 0;
      if (!m_busy) begin
         if (r != 0) begin
            for (int k = 0; k < 8; k++) begin
               if (r[(m_ptr + k) % 8]) begin
                  m_win = (m_ptr + k) % 8;
                  break;
               end
            end
            m_busy = 1;
            m_held = 1;
         end
      end else if (!r[m_win]) begin
         m_busy = 0;
         m_ptr  = (m_win + 1) % 8;
      end else if (TMO_ON && m_held >= MH) begin
         m_busy = 0;
         m_ptr  = (m_win + 1) % 8;
         m_tmo  = 1;
      end else begin
         m_held++;
      end
   endtask

   task automatic step(input logic [7:0] r);
      req = r;
      @(posedge clk);
      m_edge(r);
      #1;
   endtask

   task automatic apply_reset();
      req = 8'h00;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_reset();
      req = 8'h00;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({gnt, gnt_vld, tmo} !== 10'h000) begin
         n_err++;
         $display("FAIL reset: gnt=%h vld=%b tmo=%b want 00/0/0",
                  gnt, gnt_vld, tmo);
      end
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_single();
      logic [7:0] rs [6];
      logic [7:0] eg [6];
      rs = '{8'h04, 8'h04, 8'h04, 8'h00, 8'hff, 8'h00};
      eg = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h08, 8'h00};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(rs[i]);
         n_chk++;
         if ({gnt, gnt_vld, tmo} !== {eg[i], |eg[i], 1'b0}) begin
            n_err++;
            $display("FAIL single c%0d: gnt=%h vld=%b tmo=%b want %h/%b/0",
                     i, gnt, gnt_vld, tmo, eg[i], |eg[i]);
         end
      end
   endtask

   task automatic test_rotation();
      logic [7:0] wb;
      logic [7:0] e;
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         wb = (n % 2 == 1) ? 8'h80 : 8'h01;
         for (int c = 0; c < 3; c++) begin
            step(c == 2 ? (8'h81 & ~wb) : 8'h81);
            e = (c == 2) ? 8'h00 : wb;
            n_chk++;
            if ({gnt, gnt_vld} !== {e, |e}) begin
               n_err++;
               $display("FAIL rotation n%0d c%0d: gnt=%h vld=%b want %h/%b",
                        n, c, gnt, gnt_vld, e, |e);
            end
         end
      end
   endtask

   task automatic test_all8();
      logic [7:0] e;
      apply_reset();
      for (int k = 0; k < 9; k++) begin
         e = 8'h01 << (k % 8);
         step(8'hff);
         n_chk++;
         if ({gnt, gnt_vld} !== {e, 1'b1} || !$onehot0(gnt)) begin
            n_err++;
            $display("FAIL all8 grant k%0d: gnt=%h vld=%b want %h/1",
                     k, gnt, gnt_vld, e);
         end
         step(8'hff & ~e);
         n_chk++;
         if ({gnt, gnt_vld} !== 9'h000) begin
            n_err++;
            $display("FAIL all8 dead k%0d: gnt=%h vld=%b want 00/0",
                     k, gnt, gnt_vld);
         end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] eg [11];
      logic       et [11];
`ifdef RR_ARB_TIMEOUT_EN
      eg = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00,
             8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h02};
      et = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
`else
      for (int i = 0; i < 11; i++) begin
         eg[i] = 8'h02;
         et[i] = 1'b0;
      end
`endif
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         step(8'h0a);
         n_chk++;
         if ({gnt, gnt_vld, tmo} !== {eg[i], |eg[i], et[i]}) begin
            n_err++;
            $display("FAIL timeout c%0d: gnt=%h vld=%b tmo=%b want %h/%b/%b",
                     i, gnt, gnt_vld, tmo, eg[i], |eg[i], et[i]);
         end
      end
      step(8'h00);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(8'h20);
      step(8'h20);
      n_chk++;
      if ({gnt, gnt_vld} !== {8'h20, 1'b1}) begin
         n_err++;
         $display("FAIL midrst pre: gnt=%h vld=%b want 20/1", gnt, gnt_vld);
      end
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({gnt, gnt_vld, tmo} !== 10'h000) begin
         n_err++;
         $display("FAIL midrst async: gnt=%h vld=%b tmo=%b want 00/0/0",
                  gnt, gnt_vld, tmo);
      end
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      step(8'h21);
      n_chk++;
      if ({gnt, gnt_vld, tmo} !== {8'h01, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL midrst regrant: gnt=%h vld=%b tmo=%b want 01/1/0",
                  gnt, gnt_vld, tmo);
      end
      step(8'h00);
   endtask

   task automatic test_random();
      logic [7:0] r;
      r = 8'h00;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) r = 8'($urandom);
         if ($urandom_range(9) == 0) r = 8'h00;
         step(r);
         n_chk++;
         if ({gnt, gnt_vld, tmo} !== {m_gnt(), m_busy, m_tmo}) begin
            n_err++;
            $display("FAIL random c%0d req=%h: gnt=%h vld=%b tmo=%b want %h/%b/%b",
                     i, r, gnt, gnt_vld, tmo, m_gnt(), m_busy, m_tmo);
         end
         n_chk++;
         if (!$onehot0(gnt) || gnt_vld !== (|gnt)) begin
            n_err++;
            $display("FAIL invariant c%0d: gnt=%h vld=%b want onehot0 and vld=|gnt",
                     i, gnt, gnt_vld);
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_single();
      test_rotation();
      test_all8();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d",
               n_chk, n_err);
      $fatal(1, "watchdog");
   end

endmodule
